// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin scheduler that shares one FIFO write port among NREQ requesters.
// In IDLE it picks a winner, starting the search just after the last completed
// winner, and captures that winner's data. It then waits out `full`, issues a
// single-cycle write strobe, and returns a single-cycle ack to the winner.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   req       in   [NREQ]     per-requester level request, held until ack
//   din       in   [NREQ*DW]  packed data, requester i at din[i*DW +: DW]
//   full      in   FIFO full flag
//   ack       out  [NREQ]     one-hot pulse: winner's data written this cycle
//   fifo_wr   out  FIFO write strobe
//   fifo_din  out  [DW]       write data, zero whenever fifo_wr is low
//   busy      out  high in any state other than IDLE
//   gnt_idx   out  [IW]       index of the current or last winner
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  input  logic               full,
  output logic [NREQ-1:0]    ack,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_din,
  output logic               busy,
  output logic [IW-1:0]      gnt_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;    // last completed winner (lowest priority)
  logic [IW-1:0]   gnt_q, gnt_d;    // current winner
  logic [DW-1:0]   data_q, data_d;  // winner's data captured at grant

  logic [IW-1:0]   win_idx;
  logic            win_found;

  // Round-robin search: first set request at ptr+1, ptr+2, ... modulo NREQ.
  // Requester ptr itself is examined last, so a requester that just wrote
  // gets the lowest priority in the next arbitration.
  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Next-state and output decode. Outputs depend only on registered state and
  // data, except that `full` gates the write strobe and ack while in WRITE so
  // a late `full` suppresses the write instead of overrunning the FIFO.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    ack     = '0;
    fifo_wr = 1'b0;
    busy    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = win_idx;
          data_d  = din[int'(win_idx)*DW +: DW];
          state_d = full ? HOLD : WRITE;
        end
      end

      HOLD: begin
        busy = 1'b1;
        // Winner withdrew: abandon the grant without moving the pointer.
        if (!req[gnt_q]) begin
          state_d = IDLE;
        end else if (!full) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        busy = 1'b1;
        if (!full) begin
          fifo_wr    = 1'b1;
          ack[gnt_q] = 1'b1;
          ptr_d      = gnt_q;
          state_d    = IDLE;
        end else begin
          state_d = HOLD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);  // requester 0 searched first after reset
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign fifo_din = fifo_wr ? data_q : '0;
  assign gnt_idx  = gnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Scoreboard bench for fifo_wr_arbiter. Stimulus tasks compute the expected
// winner from the round-robin rule and push {ack, data, index} into a queue;
// a monitor pops and compares whenever the DUT presents a write.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic               clk  = 1'b0;
  logic               rst  = 1'b0;
  logic [NREQ-1:0]    req  = '0;
  logic [NREQ*DW-1:0] din  = '0;
  logic               full = 1'b0;
  logic [NREQ-1:0]    ack;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_din;
  logic               busy;
  logic [IW-1:0]      gnt_idx;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .full     (full),
    .ack      (ack),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .busy     (busy),
    .gnt_idx  (gnt_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   data;
    logic [IW-1:0]   idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   wr_cyc[$];
  int   tests       = 0;
  int   fails       = 0;
  int   writes_seen = 0;
  int   cyc         = 0;
  int   mptr        = NREQ - 1;  // model: last completed winner

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: first requester found searching p+1, p+2, ... mod NREQ.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic exp_t make_exp(input int g, input logic [NREQ*DW-1:0] d);
    exp_t e;
    e.ack    = '0;
    e.ack[g] = 1'b1;
    e.data   = d[g*DW +: DW];
    e.idx    = IW'(g);
    return e;
  endfunction

  // Monitor: every write cycle must match the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (fifo_wr || ack != '0) begin
      wr_cyc.push_back(cyc);
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, fifo_wr, ack}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_strobe", fifo_wr, 1'b1);
        check("wr_ack", ack, mon_e.ack);
        check("wr_data", fifo_din, mon_e.data);
        check("wr_gnt_idx", gnt_idx, mon_e.idx);
      end
    end else begin
      check("idle_din_zero", fifo_din, 0);
    end
  end

  // One complete transaction. Starts with a settling cycle (req low) so the
  // arbiter is in IDLE, then holds `full` for fc cycles after the grant.
  task automatic do_write(input logic [NREQ-1:0] r, input int fc,
                          input logic [NREQ*DW-1:0] din_v, input bit scramble);
    int g, n, target, fc0;
    @(negedge clk); #1;
    req  = r;
    din  = din_v;
    full = (fc > 0);
    fc0  = fc;
    g    = pick(r, mptr);
    exp_q.push_back(make_exp(g, din_v));
    target = writes_seen + 1;
    n = 0;
    while (writes_seen < target && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (writes_seen < target && full) begin
        check("stall_no_wr", fifo_wr, 1'b0);
        check("stall_busy", busy, 1'b1);
      end
      if (fc > 0) begin
        fc--;
        full = (fc > 0);
      end
      // Captured data and non-winner requests must not matter after grant.
      if (scramble && writes_seen < target) begin
        din = ~din_v;
        req = NREQ'($urandom()) | (NREQ'(1) << g);
      end
    end
    if (writes_seen < target) check("write_timeout", writes_seen, target);
    else check("write_latency", n, fc0 + 1);
    mptr = g;
    req  = '0;
  endtask

  // Winner withdraws its request while stalled in HOLD.
  task automatic do_abort(input logic [NREQ-1:0] r);
    @(negedge clk); #1;
    req  = r;
    din  = $urandom();
    full = 1'b1;
    @(negedge clk); #1;
    check("abort_hold_busy", busy, 1'b1);
    req = '0;
    @(negedge clk); #1;
    check("abort_idle_busy", busy, 1'b0);
    full = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_round_robin();
    int p, g, target, n;
    @(negedge clk); #1;
    req  = '1;
    full = 1'b0;
    din  = $urandom();
    p    = mptr;
    for (int i = 0; i < 5; i++) begin
      g = pick(req, p);
      exp_q.push_back(make_exp(g, din));
      p = g;
    end
    wr_cyc.delete();
    target = writes_seen + 5;
    n = 0;
    while (writes_seen < target && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    req = '0;
    if (writes_seen < target) check("rr_timeout", writes_seen, target);
    if (wr_cyc.size() >= 5) begin
      for (int i = 1; i < 5; i++) check("rr_spacing", wr_cyc[i] - wr_cyc[i-1], 2);
    end
    mptr = p;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_fifo_din", fifo_din, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_idx", gnt_idx, 0);
    rst = 1'b1;

    // All four requesting from reset: 0,1,2,3,0, one write every 2 cycles.
    do_round_robin();

    // Full stall on requester 2 with data A5.
    do_write(4'b0100, 5, 32'h00A5_0000, 1'b0);

    // Data captured at grant: din[3] changes after the grant edge.
    do_write(4'b1000, 0, 32'h3C00_0000, 1'b1);

    // Asynchronous reset while stalled in HOLD.
    @(negedge clk); #1;
    req  = 4'b0100;
    full = 1'b1;
    din  = $urandom();
    @(negedge clk); #1;
    check("hold_busy", busy, 1'b1);
    check("hold_gnt_idx", gnt_idx, 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ack", ack, 0);
    check("arst_fifo_wr", fifo_wr, 0);
    check("arst_busy", busy, 0);
    check("arst_gnt_idx", gnt_idx, 0);
    exp_q.delete();
    req  = '0;
    full = 1'b0;
    @(negedge clk); #1;
    rst  = 1'b1;
    mptr = NREQ - 1;
    repeat (3) @(negedge clk);

    // Abort leaves the pointer alone: 0011 then grants requester 0.
    do_abort(4'b0010);
    do_write(4'b0011, 0, $urandom(), 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 150; i++) begin
      logic [NREQ-1:0] r;
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      if ($urandom_range(0, 7) == 0) do_abort(r);
      else do_write(r, $urandom_range(0, 4), $urandom(), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
